lo_passthru_gen: RTL and testbench

Parametrised low-frequency carrier generator and pass-through for TI-style and generic LF tag reading. It derives a symmetric antenna carrier from pck0 through a programmable divider. The carrier is gated glitch-free by the ARM's ssp_dout request, so no runt pulses reach the antenna drivers. The comparator output cross_lo is synchronised and debounced before it is returned to the ARM on ssp_din. The block is a drop-in mode for the LF FPGA image and replaces the fixed 8-bit, ungated pass-through mode.

---
 rtl/lo_passthru_gen.sv | 129 ++++++++++++
 tb/tb_lo_passthru_gen.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/lo_passthru_gen.sv
// LF carrier generator with glitch-free ARM gating and debounced comparator return.
// Define LO_PASSTHRU_ADC_EN to clock the ADC in phase with the carrier; otherwise adc_clk is 0.
module lo_passthru_gen #(
  parameter int DIV_W = 8,
  parameter int DEB   = 4
) (
  input  logic             pck0,
  input  logic             rst,
  input  logic [DIV_W-1:0] divisor,
  input  logic             ssp_dout,
  input  logic             cross_lo,
  output logic             pwr_lo,
  output logic             pwr_hi,
  output logic             pwr_oe1,
  output logic             pwr_oe2,
  output logic             pwr_oe3,
  output logic             pwr_oe4,
  output logic             adc_clk,
  output logic             ssp_din,
  output logic             dbg
);

  typedef enum logic [1:0] {IDLE, DRIVE, TAIL} state_t;

  localparam logic [7:0] DEB_LAST = 8'(DEB - 1);

  state_t           state;
  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] div_l;
  logic             ant_lo;
  logic             oe;
  logic [1:0]       en_sync;
  logic [1:0]       x_sync;
  logic             en_s;
  logic             x_s;
  logic [7:0]       dcnt;
  logic             din_q;

  assign en_s = en_sync[1];
  assign x_s  = x_sync[1];

  always_ff @(posedge pck0 or posedge rst) begin
    if (rst) begin
      en_sync <= '0;
      x_sync  <= '0;
    end else begin
      en_sync <= {en_sync[0], ssp_dout};
      x_sync  <= {x_sync[0], cross_lo};
    end
  end

  // A phase only ends at a toggle point, so stopping never produces a runt pulse.
  always_ff @(posedge pck0 or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      div_l  <= '0;
      ant_lo <= 1'b0;
      oe     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (en_s) begin
            cnt    <= '0;
            div_l  <= divisor;
            ant_lo <= 1'b1;
            oe     <= 1'b1;
            state  <= DRIVE;
          end
        end
        DRIVE, TAIL: begin
          if (cnt == div_l) begin
            cnt <= '0;
            if (!en_s) begin
              ant_lo <= 1'b0;
              oe     <= 1'b0;
              state  <= IDLE;
            end else begin
              ant_lo <= !ant_lo;
              // Reload only on the rising toggle so each period stays symmetric.
              if (!ant_lo) div_l <= divisor;
              state <= DRIVE;
            end
          end else begin
            cnt   <= cnt + 1'b1;
            state <= en_s ? DRIVE : TAIL;
          end
        end
        default: begin
          state  <= IDLE;
          cnt    <= '0;
          ant_lo <= 1'b0;
          oe     <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge pck0 or posedge rst) begin
    if (rst) begin
      dcnt  <= '0;
      din_q <= 1'b0;
    end else if (x_s == din_q) begin
      dcnt <= '0;
    end else if (dcnt == DEB_LAST) begin
      din_q <= x_s;
      dcnt  <= '0;
    end else begin
      dcnt <= dcnt + 8'd1;
    end
  end

  assign pwr_lo  = ant_lo;
  assign pwr_hi  = 1'b0;
  assign pwr_oe1 = oe;
  assign pwr_oe2 = oe;
  assign pwr_oe3 = 1'b0;
  assign pwr_oe4 = oe;
  assign ssp_din = din_q;
  assign dbg     = din_q;

`ifdef LO_PASSTHRU_ADC_EN
  // ant_lo is held 0 in IDLE, so it already equals the gated carrier.
  assign adc_clk = ant_lo;
`else
  assign adc_clk = 1'b0;
`endif

endmodule

// File: tb/tb_lo_passthru_gen.sv
// Scoreboard bench for lo_passthru_gen: expected per-cycle output vectors are queued, then
// popped and compared one cycle at a time.
module tb_lo_passthru_gen;

  logic       pck0 = 1'b0;
  logic       rst;
  logic [7:0] divisor;
  logic       ssp_dout;
  logic       cross_lo;
  logic       pwr_lo, pwr_hi, pwr_oe1, pwr_oe2, pwr_oe3, pwr_oe4, adc_clk, ssp_din, dbg;

  int checks   = 0;
  int failures = 0;
  logic [8:0] q[$];

  lo_passthru_gen #(.DIV_W(8), .DEB(4)) dut (
    .pck0(pck0), .rst(rst), .divisor(divisor), .ssp_dout(ssp_dout), .cross_lo(cross_lo),
    .pwr_lo(pwr_lo), .pwr_hi(pwr_hi), .pwr_oe1(pwr_oe1), .pwr_oe2(pwr_oe2),
    .pwr_oe3(pwr_oe3), .pwr_oe4(pwr_oe4), .adc_clk(adc_clk), .ssp_din(ssp_din), .dbg(dbg)
  );

  always #5 pck0 = ~pck0;

  logic [8:0] obs;
  assign obs = {pwr_lo, pwr_oe1, pwr_oe2, pwr_oe4, pwr_hi, pwr_oe3, adc_clk, ssp_din, dbg};

  function automatic logic [8:0] mk(input logic lo, input logic oe, input logic din);
    logic adc;
`ifdef LO_PASSTHRU_ADC_EN
    adc = lo & oe;
`else
    adc = 1'b0;
`endif
    return {lo, oe, oe, oe, 1'b0, 1'b0, adc, din, din};
  endfunction

  task automatic push_n(input int n, input logic lo, input logic oe, input logic din);
    repeat (n) q.push_back(mk(lo, oe, din));
  endtask

  task automatic push_carrier(input int periods, input int half);
    repeat (periods) begin
      push_n(half, 1'b1, 1'b1, 1'b0);
      push_n(half, 1'b0, 1'b1, 1'b0);
    end
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    ssp_dout = 1'b0;
    cross_lo = 1'b0;
    q.delete();
    repeat (2) @(posedge pck0);
    #1 rst = 1'b0;
  endtask

  task automatic test_reset();
    logic [8:0] exp;
    rst = 1'b1; ssp_dout = 1'b1; cross_lo = 1'b1; divisor = 8'd3;
    #3;
    exp = '0;
    checks++;
    if (obs !== exp) begin
      failures++; $display("FAIL reset_async obs=%b exp=%b", obs, exp);
    end
    repeat (3) @(posedge pck0);
    #1;
    checks++;
    if (obs !== exp) begin
      failures++; $display("FAIL reset_held obs=%b exp=%b", obs, exp);
    end
  endtask

  task automatic test_start();
    logic [8:0] exp;
    do_reset();
    divisor = 8'd3; ssp_dout = 1'b1;
    push_n(2, 1'b0, 1'b0, 1'b0);
    push_carrier(3, 4);
    for (int i = 0; i < 26; i++) begin
      @(posedge pck0); #1;
      exp = q.pop_front();
      checks++;
      if (obs !== exp) begin
        failures++; $display("FAIL start[%0d] obs=%b exp=%b", i, obs, exp);
      end
    end
  endtask

  task automatic test_stop();
    logic [8:0] exp;
    do_reset();
    divisor = 8'd5; ssp_dout = 1'b1;
    push_n(2, 1'b0, 1'b0, 1'b0);
    push_carrier(1, 6);
    push_n(6, 1'b1, 1'b1, 1'b0);
    push_n(12, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 32; i++) begin
      @(posedge pck0); #1;
      exp = q.pop_front();
      checks++;
      if (obs !== exp) begin
        failures++; $display("FAIL stop[%0d] obs=%b exp=%b", i, obs, exp);
      end
      if (i == 15) ssp_dout = 1'b0;
    end
  endtask

  task automatic test_tail_resume();
    logic [8:0] exp;
    do_reset();
    divisor = 8'd7; ssp_dout = 1'b1;
    push_n(2, 1'b0, 1'b0, 1'b0);
    push_carrier(4, 8);
    for (int i = 0; i < 66; i++) begin
      @(posedge pck0); #1;
      exp = q.pop_front();
      checks++;
      if (obs !== exp) begin
        failures++; $display("FAIL tail_resume[%0d] obs=%b exp=%b", i, obs, exp);
      end
      if (i == 12) ssp_dout = 1'b0;
      if (i == 15) ssp_dout = 1'b1;
    end
  endtask

  task automatic test_divisor();
    logic [8:0] exp;
    do_reset();
    divisor = 8'd3; ssp_dout = 1'b1;
    push_n(2, 1'b0, 1'b0, 1'b0);
    push_carrier(1, 4);
    push_carrier(1, 10);
    push_n(10, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 40; i++) begin
      @(posedge pck0); #1;
      exp = q.pop_front();
      checks++;
      if (obs !== exp) begin
        failures++; $display("FAIL div_change[%0d] obs=%b exp=%b", i, obs, exp);
      end
      if (i == 3) divisor = 8'd9;
    end

    do_reset();
    divisor = 8'd0; ssp_dout = 1'b1;
    push_n(2, 1'b0, 1'b0, 1'b0);
    push_carrier(10, 1);
    for (int i = 0; i < 22; i++) begin
      @(posedge pck0); #1;
      exp = q.pop_front();
      checks++;
      if (obs !== exp) begin
        failures++; $display("FAIL div_zero[%0d] obs=%b exp=%b", i, obs, exp);
      end
    end

    do_reset();
    divisor = 8'd255; ssp_dout = 1'b1;
    push_n(2, 1'b0, 1'b0, 1'b0);
    push_carrier(1, 256);
    push_n(4, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 518; i++) begin
      @(posedge pck0); #1;
      exp = q.pop_front();
      checks++;
      if (obs !== exp) begin
        failures++; $display("FAIL div_max[%0d] obs=%b exp=%b", i, obs, exp);
      end
    end
  endtask

  task automatic test_debounce();
    logic [8:0] exp;
    do_reset();
    divisor = 8'd3; cross_lo = 1'b1;
    push_n(15, 1'b0, 1'b0, 1'b0);
    push_n(15, 1'b0, 1'b0, 1'b1);
    push_n(6, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 36; i++) begin
      @(posedge pck0); #1;
      exp = q.pop_front();
      checks++;
      if (obs !== exp) begin
        failures++; $display("FAIL debounce[%0d] obs=%b exp=%b", i, obs, exp);
      end
      if (i == 2)  cross_lo = 1'b0;
      if (i == 9)  cross_lo = 1'b1;
      if (i == 24) cross_lo = 1'b0;
    end
  endtask

  task automatic test_async_reset();
    logic [8:0] exp;
    do_reset();
    divisor = 8'd3; ssp_dout = 1'b1;
    push_n(2, 1'b0, 1'b0, 1'b0);
    push_n(3, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(posedge pck0); #1;
      exp = q.pop_front();
      checks++;
      if (obs !== exp) begin
        failures++; $display("FAIL areset_pre[%0d] obs=%b exp=%b", i, obs, exp);
      end
    end
    #2 rst = 1'b1;
    #1;
    exp = '0;
    checks++;
    if (obs !== exp) begin
      failures++; $display("FAIL areset_immediate obs=%b exp=%b", obs, exp);
    end
    repeat (2) @(posedge pck0);
    #1 rst = 1'b0;
    push_n(2, 1'b0, 1'b0, 1'b0);
    push_carrier(1, 4);
    for (int i = 0; i < 10; i++) begin
      @(posedge pck0); #1;
      exp = q.pop_front();
      checks++;
      if (obs !== exp) begin
        failures++; $display("FAIL areset_restart[%0d] obs=%b exp=%b", i, obs, exp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_start();
    test_stop();
    test_tail_resume();
    test_divisor();
    test_debounce();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
